step_ctrl: RTL

- Sits directly downstream of the button debouncer and consumes its debounced level outputs (step and run buttons).
- Converts those levels into single-cycle edge events.
- Runs a halt/step/run state machine that drives the processor's clock-enable (cpu_en).
- Lets the RISC core be single-stepped one instruction per button press or free-run at a divided rate.
- Also counts enabled cycles for display.

---
 rtl/step_ctrl_pkg.sv | 19 +
 rtl/step_ctrl_edge_pulse.sv | 54 +++++
 rtl/step_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/step_ctrl_pkg.sv
// step_ctrl_pkg: shared definitions for the halt/step/run controller.
// The mode encoding is also consumed by the display/LED driver, so the
// numeric values are fixed: 0 HALTED, 1 STEP, 2 RUN (3 never used).
package step_ctrl_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_HALTED = 2'd0,
        MODE_STEP   = 2'd1,
        MODE_RUN    = 2'd2
    } mode_e;

    // Widths of the internal per-step and run-divider counters; they bound
    // the legal ranges of STEP_CYCLES (1..255) and RUN_DIV (1..65535).
    localparam int STEP_CNT_W = 8;
    localparam int DIV_CNT_W  = 16;

endpackage

// File: rtl/step_ctrl_edge_pulse.sv
// edge_pulse: turns a debounced button level into a single-cycle event.
//   clk       : system clock
//   reset     : synchronous, active-high
//   level_in  : debounced button level (asynchronous to clk)
//   pulse_out : 1-cycle pulse, 3 clk cycles after level_in rises
// The detector starts disarmed and arms only after it has seen a genuine
// (post-reset) low on the synchronized level, so a button held through
// reset produces nothing until it is released and pressed again.
module edge_pulse (
    input  logic clk,
    input  logic reset,
    input  logic level_in,
    output logic pulse_out
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       prev_q,  prev_d;
    logic       armed_q, armed_d;
    logic [1:0] fill_q,  fill_d;   // fill_q[1]: sync2_q holds real sampled data
    logic       pulse_q, pulse_d;

    always_comb begin
        sync1_d = level_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        fill_d  = {fill_q[0], 1'b1};
        // The synchronizer's reset zeros must not count as a release.
        armed_d = armed_q | (fill_q[1] & ~sync2_q);
        // Registered so the event lands exactly 3 cycles after the rise.
        pulse_d = sync2_q & ~prev_q & armed_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            fill_q  <= 2'b00;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            fill_q  <= fill_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_out = pulse_q;

endmodule

// File: rtl/step_ctrl.sv
// step_ctrl: halt/step/run controller driving the processor clock-enable.
//   clk        : system clock
//   reset      : synchronous, active-high
//   step_btn   : debounced step button level
//   run_btn    : debounced run/stop toggle level
//   halt_in    : processor halt request (level)
//   cpu_en     : processor clock-enable (combinational from state/counters)
//   mode       : 0 HALTED, 1 STEP, 2 RUN
//   step_count : number of cpu_en cycles, wraps silently
//   busy       : high whenever not HALTED
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int STEP_CYCLES = 1,
    parameter int RUN_DIV     = 1,
    parameter int COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step_btn,
    input  logic               run_btn,
    input  logic               halt_in,
    output logic               cpu_en,
    output logic [MODE_W-1:0]  mode,
    output logic [COUNT_W-1:0] step_count,
    output logic               busy
);

    localparam logic [STEP_CNT_W-1:0] STEP_LOAD = STEP_CNT_W'(STEP_CYCLES);
    localparam logic [DIV_CNT_W-1:0]  DIV_LAST  = DIV_CNT_W'(RUN_DIV - 1);

    logic step_ev, run_ev;

    edge_pulse u_step_edge (
        .clk       (clk),
        .reset     (reset),
        .level_in  (step_btn),
        .pulse_out (step_ev)
    );

    edge_pulse u_run_edge (
        .clk       (clk),
        .reset     (reset),
        .level_in  (run_btn),
        .pulse_out (run_ev)
    );

    mode_e                 state_q, state_d;
    logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic [DIV_CNT_W-1:0]  div_q, div_d;
    logic [COUNT_W-1:0]    count_q, count_d;

    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        div_d      = div_q;
        cpu_en     = 1'b0;

        unique case (state_q)
            MODE_HALTED: begin
                // halt_in is deliberately ignored here; run wins over step.
                if (run_ev) begin
                    state_d = MODE_RUN;
                    div_d   = '0;
                end else if (step_ev) begin
                    state_d    = MODE_STEP;
                    step_cnt_d = STEP_LOAD;
                end
            end
            MODE_STEP: begin
                if (halt_in) begin
                    state_d = MODE_HALTED;
                end else begin
                    cpu_en     = 1'b1;
                    step_cnt_d = step_cnt_q - 1'b1;
                    if (step_cnt_q <= STEP_CNT_W'(1)) state_d = MODE_HALTED;
                end
            end
            MODE_RUN: begin
                // Any event stops the run; the enable is suppressed that cycle.
                if (halt_in || run_ev || step_ev) begin
                    state_d = MODE_HALTED;
                end else if (div_q == DIV_LAST) begin
                    cpu_en = 1'b1;
                    div_d  = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = MODE_HALTED;
        endcase

        count_d = count_q + {{(COUNT_W-1){1'b0}}, cpu_en};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= MODE_HALTED;
            step_cnt_q <= '0;
            div_q      <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            div_q      <= div_d;
            count_q    <= count_d;
        end
    end

    assign mode       = state_q;
    assign step_count = count_q;
    assign busy       = (state_q != MODE_HALTED);

endmodule
